// File: rtl/os_encoder.sv
// rtl/os_encoder.sv - transmit ordered-set encoder, byte-striped across active lanes
// Define OS_ENCODER_FORMAT_CHECK_EN to reject sets whose lane-0 symbol 0 is not COM/1E/2D/AA.
module os_encoder #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 8,
  parameter int GEN3_PIPEWIDTH = 8,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    gen,
  input  logic [4:0]    numberOfDetectedLanes,
  input  logic [2047:0] osIn,
  input  logic [4:0]    osLength,
  input  logic          osValid,
  output logic          osReady,
  output logic [511:0]  data,
  output logic          validToLMC,
  output logic          osDone,
  output logic          osError
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [2047:0]   os_q, os_d;
  logic [4:0]      len_q, len_d;
  logic [2:0]      ln_q, ln_d;
  logic [1:0]      lb_q, lb_d;
  logic [5:0]      ptr_q, ptr_d;
  logic            last_q, last_d, err_d, accept, fmt_ok;
  logic [2:0]      in_ln;
  logic [1:0]      in_lb;
  logic [4:0]      in_len;
  logic [511:0]    beat_d;
  logic [3:0]      lane_mask, lane_k;
  logic [6:0]      sym_k;
  logic [7:0]      byte_cnt;

  function automatic logic [1:0] width_log2(input int pw);
    return (pw == 32) ? 2'd2 : (pw == 16) ? 2'd1 : 2'd0;
  endfunction

  always_comb begin
    case (gen)
      3'd2:    in_lb = width_log2(GEN2_PIPEWIDTH);
      3'd3:    in_lb = width_log2(GEN3_PIPEWIDTH);
      3'd4:    in_lb = width_log2(GEN4_PIPEWIDTH);
      3'd5:    in_lb = width_log2(GEN5_PIPEWIDTH);
      default: in_lb = width_log2(GEN1_PIPEWIDTH);
    endcase
    case (numberOfDetectedLanes)
      5'd2:    in_ln = 3'd1;
      5'd4:    in_ln = 3'd2;
      5'd8:    in_ln = 3'd3;
      5'd16:   in_ln = 3'd4;
      default: in_ln = 3'd0;
    endcase
    // Lengths above 16 would spill into the next lane's field; clamp them.
    if (osLength == 5'd0)       in_len = 5'd1;
    else if (osLength > 5'd16)  in_len = 5'd16;
    else                        in_len = osLength;
  end

`ifdef OS_ENCODER_FORMAT_CHECK_EN
  assign fmt_ok = (osIn[7:0] == 8'hBC) || (osIn[7:0] == 8'h1E) ||
                  (osIn[7:0] == 8'h2D) || (osIn[7:0] == 8'hAA);
`else
  assign fmt_ok = 1'b1;
`endif

  assign last_q  = (state_q == SEND) &&
                   (({1'b0, ptr_q} + (7'd1 << lb_q)) >= {2'b00, len_q});
  assign osReady = !reset && ((state_q == IDLE) || last_q);
  assign accept  = osValid && osReady;

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    len_d   = len_q;
    ln_d    = ln_q;
    lb_d    = lb_q;
    ptr_d   = (state_q == SEND) ? ptr_q + (6'd1 << lb_q) : ptr_q;
    err_d   = 1'b0;
    if (last_q)
      state_d = IDLE;
    if (accept) begin
      if (fmt_ok) begin
        state_d = SEND;
        os_d    = osIn;
        len_d   = in_len;
        ln_d    = in_ln;
        lb_d    = in_lb;
        ptr_d   = '0;
      end else begin
        err_d = 1'b1;
      end
    end
    last_d = ({1'b0, ptr_d} + (7'd1 << lb_d)) >= {2'b00, len_d};
  end

  // Beat is built from next-state values so data can be registered with no extra latency.
  always_comb begin
    beat_d    = '0;
    lane_k    = '0;
    sym_k     = '0;
    lane_mask = 4'((5'd1 << ln_d) - 5'd1);
    byte_cnt  = 8'd1 << ({1'b0, ln_d} + {2'b00, lb_d});
    for (int k = 0; k < 64; k++) begin
      lane_k = 4'(k) & lane_mask;
      sym_k  = {1'b0, ptr_d} + 7'(k >> ln_d);
      if ((8'(k) < byte_cnt) && (sym_k < {2'b00, len_d}))
        beat_d[8*k +: 8] = os_d[{lane_k, sym_k[3:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= 5'd1;
      ln_q       <= '0;
      lb_q       <= '0;
      ptr_q      <= '0;
      data       <= '0;
      validToLMC <= 1'b0;
      osDone     <= 1'b0;
      osError    <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_q       <= os_d;
      len_q      <= len_d;
      ln_q       <= ln_d;
      lb_q       <= lb_d;
      ptr_q      <= ptr_d;
      data       <= (state_d == SEND) ? beat_d : '0;
      validToLMC <= (state_d == SEND);
      osDone     <= (state_d == SEND) && last_d;
      osError    <= err_d;
    end
  end

endmodule

// File: tb/tb_os_encoder.sv
// tb/tb_os_encoder.sv - self-checking bench for os_encoder against a striping reference model
module tb_os_encoder;
  localparam int PW1 = 8, PW2 = 16, PW3 = 16, PW4 = 32, PW5 = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    gen;
  logic [4:0]    numberOfDetectedLanes;
  logic [2047:0] osIn;
  logic [4:0]    osLength;
  logic          osValid;
  logic          osReady;
  logic [511:0]  data;
  logic          validToLMC, osDone, osError;

  int checks = 0;
  int errors = 0;

  os_encoder #(
    .GEN1_PIPEWIDTH(PW1), .GEN2_PIPEWIDTH(PW2), .GEN3_PIPEWIDTH(PW3),
    .GEN4_PIPEWIDTH(PW4), .GEN5_PIPEWIDTH(PW5)
  ) dut (
    .clk(clk), .reset(reset), .gen(gen), .numberOfDetectedLanes(numberOfDetectedLanes),
    .osIn(osIn), .osLength(osLength), .osValid(osValid), .osReady(osReady),
    .data(data), .validToLMC(validToLMC), .osDone(osDone), .osError(osError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic int lanes_of(input int v);
    if (v == 1 || v == 2 || v == 4 || v == 8 || v == 16) return v;
    return 1;
  endfunction

  function automatic int bytes_of(input int g);
    case (g)
      2: return PW2 / 8;
      3: return PW3 / 8;
      4: return PW4 / 8;
      5: return PW5 / 8;
      default: return PW1 / 8;
    endcase
  endfunction

  // Byte k of beat j carries lane k%n, symbol j*b + k/n.
  function automatic logic [511:0] model_beat(input logic [2047:0] os, input int len,
                                              input int n, input int b, input int j);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < n * b; k++) begin
      int sym;
      sym = j * b + k / n;
      if (sym < len) r[8*k +: 8] = os[128*(k % n) + 8*sym +: 8];
    end
    return r;
  endfunction

  function automatic logic [2047:0] rand_os();
    logic [2047:0] r;
    for (int i = 0; i < 64; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input logic [2047:0] os, input int len, input int g, input int lanes);
    osIn = os;
    osLength = 5'(len);
    gen = 3'(g);
    numberOfDetectedLanes = 5'(lanes);
  endtask

  task automatic expect_beats(input logic [2047:0] os, input int len, input int g,
                              input int lanes, input string tag);
    int l, n, b, beats;
    l = (len == 0) ? 1 : len;
    n = lanes_of(lanes);
    b = bytes_of(g);
    beats = (l + b - 1) / b;
    for (int j = 0; j < beats; j++) begin
      @(negedge clk);
      chk({tag, ".valid"}, j, 512'(validToLMC), 512'(1'b1));
      chk({tag, ".data"},  j, data, model_beat(os, l, n, b, j));
      chk({tag, ".done"},  j, 512'(osDone), 512'(j == beats - 1));
      chk({tag, ".ready"}, j, 512'(osReady), 512'(j == beats - 1));
      chk({tag, ".err"},   j, 512'(osError), 512'(1'b0));
    end
  endtask

  task automatic run_set(input logic [2047:0] os, input int len, input int g,
                         input int lanes, input string tag);
    @(negedge clk);
    drive(os, len, g, lanes);
    osValid = 1'b1;
    chk({tag, ".rdy_idle"}, 0, 512'(osReady), 512'(1'b1));
    @(posedge clk);
    #1;
    osValid = 1'b0;
    drive(rand_os(), $urandom_range(0, 16), $urandom_range(0, 7), $urandom_range(0, 31));
    expect_beats(os, len, g, lanes, tag);
    @(negedge clk);
    chk({tag, ".idle_valid"}, 0, 512'(validToLMC), 512'(1'b0));
    chk({tag, ".idle_done"},  0, 512'(osDone), 512'(1'b0));
    chk({tag, ".idle_ready"}, 0, 512'(osReady), 512'(1'b1));
  endtask

  initial begin
    logic [2047:0] os, os_b;
    int lopt[6];
    lopt = '{1, 2, 3, 4, 8, 16};

    reset = 1'b1;
    osValid = 1'b0;
    drive('0, 0, 1, 1);
    repeat (2) @(negedge clk);
    chk("rst.data",  0, data, '0);
    chk("rst.valid", 0, 512'(validToLMC), 512'(1'b0));
    chk("rst.done",  0, 512'(osDone), 512'(1'b0));
    chk("rst.err",   0, 512'(osError), 512'(1'b0));
    chk("rst.ready", 0, 512'(osReady), 512'(1'b0));
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst.ready", 0, 512'(osReady), 512'(1'b1));
    chk("post_rst.valid", 0, 512'(validToLMC), 512'(1'b0));

    os = rand_os();
    os[7:0] = 8'hBC;
    os[127:120] = 8'h4A;
    run_set(os, 16, 1, 1, "ts1_x1");

    os = '0;
    for (int l = 0; l < 4; l++) begin
      os[128*l +: 8] = 8'hBC;
      for (int s = 1; s < 4; s++) os[128*l + 8*s +: 8] = 8'h1C;
    end
    run_set(os, 4, 1, 4, "skp_x4");

    os = rand_os();
    os[7:0] = 8'hBC;
    run_set(os, 5, 2, 2, "x2_b2_len5");

    os = rand_os();
    os[7:0] = 8'h1E;
    run_set(os, 16, 4, 16, "x16_b4");

    // Back-to-back: osValid stays high across two sets.
    os = rand_os();
    os[7:0] = 8'hBC;
    os_b = rand_os();
    os_b[7:0] = 8'hBC;
    @(negedge clk);
    drive(os, 16, 1, 1);
    osValid = 1'b1;
    @(posedge clk);
    #1;
    osIn = os_b;
    expect_beats(os, 16, 1, 1, "b2b_a");
    @(posedge clk);
    #1;
    osValid = 1'b0;
    osIn = rand_os();
    expect_beats(os_b, 16, 1, 1, "b2b_b");
    @(negedge clk);
    chk("b2b.end_valid", 0, 512'(validToLMC), 512'(1'b0));

    // Reset mid-set aborts it.
    os = rand_os();
    os[7:0] = 8'hBC;
    @(negedge clk);
    drive(os, 16, 1, 1);
    osValid = 1'b1;
    @(posedge clk);
    #1;
    osValid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk("abort.data", j, data, model_beat(os, 16, 1, 1, j));
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort.data0",  0, data, '0);
    chk("abort.valid0", 0, 512'(validToLMC), 512'(1'b0));
    chk("abort.done0",  0, 512'(osDone), 512'(1'b0));
    chk("abort.ready0", 0, 512'(osReady), 512'(1'b0));
    reset = 1'b0;
    @(negedge clk);
    chk("abort.ready1", 0, 512'(osReady), 512'(1'b1));
    chk("abort.valid1", 0, 512'(validToLMC), 512'(1'b0));
    os = rand_os();
    os[7:0] = 8'hBC;
    run_set(os, 16, 1, 1, "after_abort");

    os = rand_os();
    os[7:0] = 8'h55;
`ifdef OS_ENCODER_FORMAT_CHECK_EN
    @(negedge clk);
    drive(os, 16, 1, 1);
    osValid = 1'b1;
    @(posedge clk);
    #1;
    osValid = 1'b0;
    @(negedge clk);
    chk("fmt.err",    0, 512'(osError), 512'(1'b1));
    chk("fmt.valid",  0, 512'(validToLMC), 512'(1'b0));
    @(negedge clk);
    chk("fmt.err_clr", 0, 512'(osError), 512'(1'b0));
    chk("fmt.valid1",  0, 512'(validToLMC), 512'(1'b0));
    chk("fmt.ready",   0, 512'(osReady), 512'(1'b1));
`else
    run_set(os, 16, 1, 1, "nofmt_55");
`endif

    for (int i = 0; i < 24; i++) begin
      os = rand_os();
      os[7:0] = 8'hAA;
      run_set(os, $urandom_range(0, 16), $urandom_range(0, 7), lopt[$urandom_range(0, 5)], "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/os_encoder.md
# os_encoder

Transmit-side ordered-set encoder for the Gen1–Gen5 physical layer. It accepts one complete per-lane ordered set (TS1, TS2, SKP, EIOS, and so on) from the LTSSM/ordered-set generator. It serializes that set onto the PIPE-side data bus, one beat per clock, byte-striped across the active lanes. The byte layout is exactly the one the receive-side ordered-set decoder de-stripes, so a loopback of this block's output reproduces the original per-lane ordered set.

## Interface
Parameters:
- GEN1_PIPEWIDTH, 8, bits per lane per clock at Gen1 (legal values 8/16/32).
- GEN2_PIPEWIDTH, 8, same for Gen2.
- GEN3_PIPEWIDTH, 8, same for Gen3.
- GEN4_PIPEWIDTH, 8, same for Gen4.
- GEN5_PIPEWIDTH, 8, same for Gen5.

Ports:
- clk  input  1  single clock for the block.
- reset  input  1  synchronous reset, active-high.
- gen  input  3  rate: 1..5 selects GEN1..GEN5_PIPEWIDTH.
- numberOfDetectedLanes  input  5  active lanes: 1/2/4/8/16.
- osIn  input  2048  ordered set. Lane L occupies [128L +: 128]; symbol s of that lane is at [128L+8s +: 8].
- osLength  input  5  symbols per lane, 1..16 (16 = TS, 4 = Gen1/2 SKP).
- osValid  input  1  osIn/osLength valid.
- osReady  output  1  block accepts an ordered set this cycle.
- data  output  512  striped PIPE data; unused upper bits are 0.
- validToLMC  output  1  data beat valid.
- osDone  output  1  one-cycle pulse with the last beat of an ordered set.
- osError  output  1  one-cycle pulse on a rejected ordered set (see Configuration).

## Operation
- Lane count N is mapped from numberOfDetectedLanes: 1→1, 2→2, 4→4, 8→8, 16→16. Any other value is treated as N=1.
- Bytes per lane per beat: B = PIPEWIDTH(gen)/8. An undefined gen code uses GEN1.
- Beat width is N·B bytes. Configurations where N·B > 64 are unsupported.
- Accept: a handshake occurs on a cycle where osValid && osReady. On accept the block registers:
  - osIn and osLength (a value of 0 is treated as 1);
  - N and B. These stay frozen for the whole ordered set; input changes mid-set are ignored.
- FSM has two states:
  - IDLE: osReady=1. An accept moves the FSM to SEND and sets symPtr=0.
  - SEND: each cycle emits one beat. Output byte k (k = 0..N·B−1) = lane (k mod N), symbol symPtr + (k div N). Symbols at index ≥ osLength are driven as 8'h00.
  - After each beat, symPtr increments by B.
  - The last beat is the one where symPtr+B ≥ osLength. On it, osDone=1 and osReady=1.
  - On the last beat, an accept goes back-to-back: the next set's first beat follows in the very next cycle. Without an accept, the FSM returns to IDLE.
- The beat count per ordered set is ceil(osLength/B). Example: x2 lanes, B=1, osLength=16 gives 16 beats of 2 bytes.
- validToLMC=1 exactly on SEND beats.

## Timing
- All outputs are registered.
- Reset values: data=0, validToLMC=0, osDone=0, osError=0, osReady=0 in the reset cycle, then 1 (IDLE).
- Latency: the first beat appears on data/validToLMC in the cycle after accept.
- There is no gap between beats of one set, and no gap between back-to-back sets.
- osReady is combinationally derived from state only (IDLE or last SEND beat), never from osValid.
- osValid while osReady=0 is ignored and holds no data; the upstream block must keep osValid asserted until accepted.
- Reset high mid-set aborts the set. On the next edge, data=0, validToLMC=0 and the FSM is in IDLE. osDone is not pulsed for the aborted set.
- Simultaneous reset and accept: reset wins and the ordered set is dropped.

## Configuration
- OS_ENCODER_FORMAT_CHECK_EN defined:
  - On accept, lane-0 symbol 0 must be one of 8'hBC (COM), 8'h1E, 8'h2D or 8'hAA.
  - Otherwise the set is discarded: osError pulses one cycle after accept, with no beats, no osDone, and the FSM stays in (or returns to) IDLE.
- Not defined: osError is held 0 and every accepted set is transmitted unchanged.

## Test plan
- x1, gen=1, B=1, TS1 with osLength=16, lane-0 symbols BC,..,4A → 16 beats with data[7:0] = the symbols in order; osDone on beat 16; osReady low during beats 1–15.
- x4, B=1, osLength=4, SKP BC,1C,1C,1C on all lanes → 4 beats. Beat 0 data[31:0] = BCBCBCBC; beats 1–3 = 1C1C1C1C; upper bits 0.
- x2, GEN3_PIPEWIDTH=16, gen=3, osLength=5 → 3 beats. Beat 0 bytes = L0S0, L1S0, L0S1, L1S1. The last beat's symbol-5 bytes are 00.
- Back-to-back: osValid held high with two TS2 sets → 32 consecutive validToLMC cycles and two osDone pulses 16 cycles apart.
- Reset asserted at beat 7 of a TS1 → next cycle data=0, validToLMC=0, osReady=1 afterwards; a new set then starts cleanly at symbol 0.
- With OS_ENCODER_FORMAT_CHECK_EN, lane-0 symbol 0 = 8'h55 → osError pulse, no validToLMC. Without the macro → 16 beats transmitted.
